sqrt_pipe_stream: RTL and testbench
===================================

Name: sqrt_pipe_stream

Overview:
Fully pipelined integer square-root unit with valid/ready streaming handshake and back-pressure. It is the parametrised successor to the fixed-latency sqrt chain. It adds optional fractional result bits, a configurable number of iterations per pipeline register, and a sideband tag carried with each sample. It sits between the variance accumulator and the stdev output formatter.

Parameters:
INPUT_WIDTH, 28, radicand width in bits; must be even and at least 2.
FRAC_BITS, 0, extra fractional result bits; radicand is internally scaled by 2^(2*FRAC_BITS).
STAGES_PER_REG, 1, combinational iterations between pipeline registers (1..R).
TAG_WIDTH, 8, sideband tag width, passed through unchanged; minimum 1.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  unit can accept a sample this cycle
in_data  in  INPUT_WIDTH  unsigned radicand
in_tag  in  TAG_WIDTH  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  R  floor(sqrt(in_data * 2^(2*FRAC_BITS))), where R = INPUT_WIDTH/2 + FRAC_BITS
out_remainder  out  R+1  scaled radicand minus out_result squared
out_tag  out  TAG_WIDTH  tag of the sample on the output

Behaviour:
- Iterations N = R; pipeline depth D = ceil(N/STAGES_PER_REG) register stages.
- Each iteration uses the restoring digit-by-digit method:
  - shift in 2 radicand bits;
  - trial = (rem<<2 | bits) - (res<<2 | 1);
  - if trial >= 0, then rem = trial and res = res<<1 | 1; else rem = shifted value and res = res<<1.
- Radicand is extended with 2*FRAC_BITS low zero bits before iteration 0.
- Every pipeline register holds {valid, remaining radicand bits, partial rem, partial res, tag}.
  - Radicand width shrinks by 2*STAGES_PER_REG per stage.
  - Partial widths grow per iteration; no truncation is allowed.
- Global stall: advance = !out_valid | out_ready. Every stage register loads only when advance=1.
  - in_ready = advance (combinational).
  - Input is accepted when in_valid & in_ready.
- Latency: a sample accepted at cycle t appears with out_valid=1 at cycle t+D if never stalled. Each stall cycle adds one.
- Bubbles propagate: stage valid = upstream valid, captured on advance. No fill counter.
- Output hold: while out_valid & !out_ready, out_result, out_remainder and out_tag stay stable.
- Output gating: out_result and out_remainder are 0 whenever out_valid=0. out_tag is unspecified when out_valid=0.
- Throughput: one sample per cycle when out_ready is held high.
- Ordering: results emerge in acceptance order; no loss, no duplication.
- Reset (reset=0, sampled at clk):
  - all stage valid bits clear, so out_valid=0 and outputs are 0 from the next cycle;
  - in_ready=1 during and after reset, but inputs presented while reset=0 are discarded;
  - datapath registers are not reset;
  - reset mid-operation discards all in-flight samples; none of them ever emerges.
- Boundaries:
  - in_data=0 gives result 0, remainder 0.
  - in_data=2^INPUT_WIDTH-1 must not overflow the remainder (maximum value is 2*result).
- Elaboration: error if INPUT_WIDTH is odd or STAGES_PER_REG is out of range.

Decomposition:
- Package sqrt_pkg:
  - function sqrt_result_width(INPUT_WIDTH, FRAC_BITS);
  - function sqrt_depth(N, STAGES_PER_REG);
  - clog2 moved from math.v into sqrt_pkg.
- Sub-module sqrt_iter_step: purely combinational single iteration, parametrised on the partial width of its iteration index. It is instantiated N times in a generate loop. Registers are inserted after every STAGES_PER_REG-th step and after the last step.

Test Plan:
- Defaults, out_ready=1, single sample 1000000 -> after exactly 14 cycles: out_valid=1, result=1000, remainder=0, tag echoed.
- Extremes 0 and 268435455 back-to-back -> (0,0), then (16383, 32766) on consecutive cycles; in_ready stays 1.
- FRAC_BITS=4, in_data=2 -> after 18 cycles: result=22 (1.375 in Q.4), remainder=28.
- STAGES_PER_REG=3, defaults otherwise, in_data=144 -> latency 5 cycles, result=12, remainder=0.
- Stream of 20 random samples with tags 0..19, out_ready toggled pseudo-randomly -> all 20 results match a reference model, in tag order, and outputs are stable during every stall.
- Assert reset for 1 cycle with 6 samples in flight -> out_valid=0 the next cycle, none of the 6 tags ever appears, and a post-reset sample 81 returns result 9 after 14 cycles.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared helpers for the pipelined square-root unit.
//   clog2             - ceiling log2 of a positive integer
//   sqrt_result_width - result width R = INPUT_WIDTH/2 + FRAC_BITS
//   sqrt_depth        - register stages D = ceil(N / STAGES_PER_REG)
package sqrt_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int sqrt_result_width(input int input_width, input int frac_bits);
        return input_width / 2 + frac_bits;
    endfunction

    function automatic int sqrt_depth(input int n, input int stages_per_reg);
        return (n + stages_per_reg - 1) / stages_per_reg;
    endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// sqrt_iter_step: one combinational restoring digit-by-digit square-root
// iteration. W is the partial width entering this iteration (index + 1).
//   i_rem  [W-1:0] partial remainder so far
//   i_res  [W-1:0] partial root so far
//   i_bits [1:0]   next two radicand bits, MSB first
//   o_rem  [W:0]   updated remainder (never exceeds 2*o_res, so W+1 bits suffice)
//   o_res  [W:0]   updated root
module sqrt_iter_step #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_res,
    input  logic [1:0]   i_bits,
    output logic [W:0]   o_rem,
    output logic [W:0]   o_res
);

    logic [W+1:0] w_shift;
    logic [W+1:0] w_sub;
    logic [W:0]   w_diff;
    logic         w_ge;

    assign w_shift = {i_rem, i_bits};
    assign w_sub   = {i_res, 2'b01};
    assign w_ge    = (w_shift >= w_sub);
    // When the trial is non-negative the true difference fits in W+1 bits,
    // so the modular low-bit subtraction gives the exact value.
    assign w_diff  = w_shift[W:0] - w_sub[W:0];
    // On a failed trial the shifted value is at most 4*i_res, which also
    // fits in W+1 bits, so dropping the MSB loses nothing.
    assign o_rem   = w_ge ? w_diff : w_shift[W:0];
    assign o_res   = {i_res, w_ge};

endmodule

// File: rtl/sqrt_pipe_stream.sv
// sqrt_pipe_stream: fully pipelined integer square root with valid/ready
// streaming and a global stall. One restoring iteration per result bit;
// a register bank after every STAGES_PER_REG iterations and after the last.
//   clk, reset     clock; synchronous active-low reset (clears valid bits only)
//   in_valid/ready input handshake; in_ready = advance
//   in_data        unsigned radicand, scaled internally by 2^(2*FRAC_BITS)
//   in_tag         sideband tag, carried with the sample
//   out_valid/ready output handshake
//   out_result     floor(sqrt(scaled radicand)), 0 when !out_valid
//   out_remainder  scaled radicand - out_result^2, 0 when !out_valid
//   out_tag        tag of the sample on the output
module sqrt_pipe_stream
    import sqrt_pkg::*;
#(
    parameter int INPUT_WIDTH    = 28,
    parameter int FRAC_BITS      = 0,
    parameter int STAGES_PER_REG = 1,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [INPUT_WIDTH-1:0]                             in_data,
    input  logic [TAG_WIDTH-1:0]                               in_tag,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [sqrt_result_width(INPUT_WIDTH, FRAC_BITS)-1:0] out_result,
    output logic [sqrt_result_width(INPUT_WIDTH, FRAC_BITS):0]   out_remainder,
    output logic [TAG_WIDTH-1:0]                               out_tag
);

    localparam int R    = sqrt_result_width(INPUT_WIDTH, FRAC_BITS);
    localparam int RADW = 2 * R;
    localparam int D    = sqrt_depth(R, STAGES_PER_REG);

    if ((INPUT_WIDTH % 2) != 0 || INPUT_WIDTH < 2) begin : g_bad_width
        $error("sqrt_pipe_stream: INPUT_WIDTH must be even and >= 2");
    end
    if (STAGES_PER_REG < 1 || STAGES_PER_REG > R || D < 1) begin : g_bad_spr
        $error("sqrt_pipe_stream: STAGES_PER_REG must be in 1..R");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("sqrt_pipe_stream: TAG_WIDTH must be >= 1");
    end

    logic            w_out_valid;
    logic            w_advance;
    logic [RADW-1:0] w_scaled;

    // Reset term keeps in_ready high during reset even if the output was
    // stalled; the valid bits are being cleared anyway.
    assign w_advance = !w_out_valid || out_ready || !reset;
    assign in_ready  = w_advance;
    assign w_scaled  = RADW'(in_data) << (2 * FRAC_BITS);

    for (genvar k = 0; k < R; k++) begin : g_it
        localparam int RWI = 2 * (R - k);
        localparam int RWO = (k == R - 1) ? 1 : RWI - 2;
        localparam bit REG = ((k + 1) % STAGES_PER_REG == 0) || (k == R - 1);

        logic                 w_vld_i, w_vld_n;
        logic [TAG_WIDTH-1:0] w_tag_i, w_tag_n;
        logic [RWI-1:0]       w_rad_i;
        logic [RWO-1:0]       w_rad_n;
        logic [k:0]           w_rem_i, w_res_i;
        logic [k+1:0]         w_rem_s, w_res_s, w_rem_n, w_res_n;

        if (k == 0) begin : g_src
            assign w_vld_i = in_valid;
            assign w_tag_i = in_tag;
            assign w_rad_i = w_scaled;
            assign w_rem_i = '0;
            assign w_res_i = '0;
        end else begin : g_src
            assign w_vld_i = g_it[k-1].w_vld_n;
            assign w_tag_i = g_it[k-1].w_tag_n;
            assign w_rad_i = g_it[k-1].w_rad_n;
            assign w_rem_i = g_it[k-1].w_rem_n;
            assign w_res_i = g_it[k-1].w_res_n;
        end

        sqrt_iter_step #(.W(k + 1)) u_step (
            .i_rem  (w_rem_i),
            .i_res  (w_res_i),
            .i_bits (w_rad_i[RWI-1 -: 2]),
            .o_rem  (w_rem_s),
            .o_res  (w_res_s)
        );

        if (REG) begin : g_reg
            logic                 r_vld;
            logic [TAG_WIDTH-1:0] r_tag;
            logic [k+1:0]         r_rem, r_res;

            always_ff @(posedge clk) begin
                if (!reset)
                    r_vld <= 1'b0;
                else if (w_advance)
                    r_vld <= w_vld_i;
            end

            // Datapath is not reset; valid gates everything downstream.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    r_tag <= w_tag_i;
                    r_rem <= w_rem_s;
                    r_res <= w_res_s;
                end
            end

            assign w_vld_n = r_vld;
            assign w_tag_n = r_tag;
            assign w_rem_n = r_rem;
            assign w_res_n = r_res;
        end else begin : g_comb
            assign w_vld_n = w_vld_i;
            assign w_tag_n = w_tag_i;
            assign w_rem_n = w_rem_s;
            assign w_res_n = w_res_s;
        end

        // Remaining radicand shrinks by two bits per iteration; nothing is
        // left after the last one, so a dummy bit is tied off there.
        if (k == R - 1) begin : g_rad
            assign w_rad_n = '0;
        end else if (REG) begin : g_rad
            logic [RWO-1:0] r_rad;
            always_ff @(posedge clk) begin
                if (w_advance)
                    r_rad <= w_rad_i[RWO-1:0];
            end
            assign w_rad_n = r_rad;
        end else begin : g_rad
            assign w_rad_n = w_rad_i[RWO-1:0];
        end
    end

    assign w_out_valid   = g_it[R-1].w_vld_n;
    assign out_valid     = w_out_valid;
    assign out_result    = w_out_valid ? g_it[R-1].w_res_n[R-1:0] : '0;
    assign out_remainder = w_out_valid ? g_it[R-1].w_rem_n : '0;
    assign out_tag       = g_it[R-1].w_tag_n;

    // Final root MSB is structurally zero; last radicand slot is a dummy.
    logic w_unused;
    assign w_unused = ^{g_it[R-1].w_res_n[R], g_it[R-1].w_rad_n};

endmodule

// File: tb/tb_sqrt_pipe_stream.sv
// Scoreboard bench: three DUT configurations (defaults, FRAC_BITS=4,
// STAGES_PER_REG=3). Drivers push expected results; a forked monitor pops
// and compares on every output handshake and checks stall hold / gating.
module tb_sqrt_pipe_stream;

    typedef struct {
        int          d;
        logic [31:0] res;
        logic [31:0] rem;
        logic [7:0]  tag;
        int          exp_cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iv   [3];
    logic        ir   [3];
    logic [27:0] din  [3];
    logic [7:0]  tin  [3];
    logic        ov   [3];
    logic        ordy [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0]  otag [3];
    logic [31:0] ores [3];
    logic [31:0] orem [3];
    logic [13:0] res0, res2;
    logic [17:0] res1;
    logic [14:0] rem0, rem2;
    logic [18:0] rem1;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  rnd_rdy = 1'b0;
    int  lat [3] = '{14, 18, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ordy[0] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        ordy[1] = 1'b1;
        ordy[2] = 1'b1;
    end

    sqrt_pipe_stream u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0]), .in_tag(tin[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_result(res0), .out_remainder(rem0), .out_tag(otag[0]));

    sqrt_pipe_stream #(.FRAC_BITS(4)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1]), .in_tag(tin[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_result(res1), .out_remainder(rem1), .out_tag(otag[1]));

    sqrt_pipe_stream #(.STAGES_PER_REG(3)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[2]), .in_tag(tin[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_result(res2), .out_remainder(rem2), .out_tag(otag[2]));

    assign ores[0] = 32'(res0);
    assign ores[1] = 32'(res1);
    assign ores[2] = 32'(res2);
    assign orem[0] = 32'(rem0);
    assign orem[1] = 32'(rem1);
    assign orem[2] = 32'(rem2);

    // Reference: binary-search integer square root.
    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] lo, hi, mid;
        lo = 64'd0;
        hi = 64'd1 << 32;
        while (hi - lo > 64'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    task automatic monitor();
        bit          p_stall [3];
        logic [31:0] p_res [3];
        logic [31:0] p_rem [3];
        logic [7:0]  p_tag [3];
        int          idx;
        for (int d = 0; d < 3; d++) p_stall[d] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (p_stall[d]) begin
                    checks++;
                    if (!ov[d] || ores[d] != p_res[d] || orem[d] != p_rem[d] || otag[d] != p_tag[d]) begin
                        errors++;
                        $display("FAIL hold dut%0d: got v=%0d res=%0d rem=%0d tag=%0d, need res=%0d rem=%0d tag=%0d",
                                 d, ov[d], ores[d], orem[d], otag[d], p_res[d], p_rem[d], p_tag[d]);
                    end
                end
                if (!ov[d]) begin
                    checks++;
                    if (ores[d] != 0 || orem[d] != 0) begin
                        errors++;
                        $display("FAIL gating dut%0d: res=%0d rem=%0d while idle, need 0", d, ores[d], orem[d]);
                    end
                end
                if (ov[d] && ordy[d]) begin
                    idx = -1;
                    for (int i = 0; i < sbq.size(); i++) begin
                        if (sbq[i].d == d) begin
                            idx = i;
                            break;
                        end
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected dut%0d: output tag=%0d res=%0d, need none", d, otag[d], ores[d]);
                    end else begin
                        if (ores[d] != sbq[idx].res || orem[d] != sbq[idx].rem || otag[d] != sbq[idx].tag) begin
                            errors++;
                            $display("FAIL result dut%0d: got res=%0d rem=%0d tag=%0d, need res=%0d rem=%0d tag=%0d",
                                     d, ores[d], orem[d], otag[d], sbq[idx].res, sbq[idx].rem, sbq[idx].tag);
                        end
                        if (sbq[idx].exp_cyc >= 0) begin
                            checks++;
                            if (cyc != sbq[idx].exp_cyc) begin
                                errors++;
                                $display("FAIL latency dut%0d tag=%0d: got cycle %0d, need %0d",
                                         d, otag[d], cyc, sbq[idx].exp_cyc);
                            end
                        end
                        sbq.delete(idx);
                    end
                end
                p_stall[d] = ov[d] && !ordy[d] && reset;
                p_res[d] = ores[d];
                p_rem[d] = orem[d];
                p_tag[d] = otag[d];
            end
        end
    endtask

    // Present one sample, hold until accepted; push expectation at acceptance.
    task automatic send(input int d, input logic [27:0] data, input logic [7:0] tag,
                        input logic [31:0] er, input logic [31:0] erem, input bit chk);
        sb_t e;
        int  n;
        n = 0;
        iv[d]  = 1'b1;
        din[d] = data;
        tin[d] = tag;
        forever begin
            @(negedge clk);
            if (ir[d]) break;
            n++;
            if (n > 200) break;
        end
        if (!ir[d]) begin
            checks++;
            errors++;
            $display("FAIL accept dut%0d tag=%0d: in_ready=0 for %0d cycles, need 1", d, tag, n);
        end else begin
            if (chk) begin
                checks++;
                if (n != 0) begin
                    errors++;
                    $display("FAIL in_ready dut%0d tag=%0d: waited %0d cycles, need 0", d, tag, n);
                end
            end
            e.d = d;
            e.res = er;
            e.rem = erem;
            e.tag = tag;
            e.exp_cyc = chk ? cyc + lat[d] : -1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, need 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [27:0] rv;
        logic [31:0] r;
        for (int d = 0; d < 3; d++) begin
            iv[d]  = 1'b0;
            din[d] = '0;
            tin[d] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: out_valid=%0d in_ready=%0d, need 0/1", d, ov[d], ir[d]);
            end
        end
        @(posedge clk);
        #1;

        send(0, 28'd1000000, 8'hA5, 32'd1000, 32'd0, 1'b1);
        wait_drain();

        send(0, 28'd0, 8'h01, 32'd0, 32'd0, 1'b1);
        send(0, 28'hFFFFFFF, 8'h02, 32'd16383, 32'd32766, 1'b1);
        wait_drain();

        send(1, 28'd2, 8'h33, 32'd22, 32'd28, 1'b1);
        wait_drain();
        send(1, 28'hFFFFFFF, 8'h34, 32'd262143, 32'd524031, 1'b1);
        send(1, 28'd0, 8'h35, 32'd0, 32'd0, 1'b1);
        wait_drain();

        send(2, 28'd144, 8'h44, 32'd12, 32'd0, 1'b1);
        wait_drain();
        send(2, 28'hFFFFFFF, 8'h45, 32'd16383, 32'd32766, 1'b1);
        send(2, 28'd99, 8'h46, 32'd9, 32'd18, 1'b1);
        wait_drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rv = 28'($urandom);
            r  = isqrt({36'd0, rv});
            send(0, rv, 8'(i), r, 32'(rv) - r * r, 1'b0);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            rv = 28'(5000 + i * 1234);
            r  = isqrt({36'd0, rv});
            send(0, rv, 8'(100 + i), r, 32'(rv) - r * r, 1'b0);
        end
        reset = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: out_valid=%0d after reset, need 0", ov[0]);
        end
        @(posedge clk);
        #1;
        send(0, 28'd81, 8'h77, 32'd9, 32'd0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
